edge_event_detector: RTL

EDGE_EVENT_DETECTOR -- requirements
Module: edge_event_detector

---
 rtl/edge_event_detector.sv | 82 ++++++++
 1 files changed

// File: rtl/edge_event_detector.sv
// Multi-channel edge detector: synchroniser, shared-length glitch filter, event pulses and sticky flags.
// Define EDGE_EVENT_DETECTOR_SYNC_EN to insert the SYNC_STAGES-deep input synchroniser.
module edge_event_detector #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   sig_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [FILTER_W-1:0]   filt_len,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   pulse_out,
  output logic [CHANNELS-1:0]   flag_out,
  output logic [CHANNELS-1:0]   level_out,
  output logic                  any_flag
);

  if (CHANNELS < 1 || CHANNELS > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_param_check
    $error("edge_event_detector: parameter out of range");
  end

  logic [CHANNELS-1:0] synced;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] event_hit;
  logic [FILTER_W-1:0] cnt_q [CHANNELS];

`ifdef EDGE_EVENT_DETECTOR_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst_n) sync_q[i] <= '0;
      else        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sig_in[i]};
    end
  end

  always_comb begin
    synced = '0;
    for (int i = 0; i < CHANNELS; i++) synced[i] = sync_q[i][SYNC_STAGES-1];
  end
`else
  // Inputs are assumed already synchronous to clk in this build.
  assign synced = sig_in;
`endif

  // The >= compare lets a shortened filt_len take effect mid-count.
  always_comb begin
    accept    = '0;
    event_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      accept[i]    = (synced[i] != level_out[i]) && (cnt_q[i] >= filt_len);
      event_hit[i] = accept[i] && ((synced[i] && mode[2*i]) || (!synced[i] && mode[2*i+1]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_out <= '0;
      pulse_out <= '0;
      flag_out  <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (synced[i] == level_out[i]) begin
          cnt_q[i] <= '0;
        end else if (accept[i]) begin
          level_out[i] <= synced[i];
          cnt_q[i]     <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
      pulse_out <= event_hit;
      flag_out  <= event_hit | (flag_out & ~clr);
    end
  end

  assign any_flag = |flag_out;

endmodule
